// File: rtl/prefix_divider_pkg.sv
// div_pkg: shared state encoding and sizing for the prefix divider
package div_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);
  typedef enum logic [2:0] {IDLE, SPECIAL, CALC, FIXUP, DONE} div_state_e;
endpackage

// File: rtl/prefix_divider_sub.sv
// prefix_sub: combinational a - b as a + ~b + 1 through a Kogge-Stone carry tree
module prefix_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  localparam int L = $clog2(N);
  logic [N-1:0] g, p, c;
  logic [N-1:0] gl [0:L];
  logic [N-1:0] pl [0:L-1];
  assign g = a & ~b;
  assign p = a ^ ~b;
  // the +1 carry-in is folded into bit 0 as a generate
  assign gl[0] = {g[N-1:1], g[0] | p[0]};
  assign pl[0] = p;
  genvar k, i;
  for (k = 0; k < L; k++) begin : g_lvl
    localparam int D = 1 << k;
    for (i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][i-D]);
        if (k + 1 < L) begin : g_p
          assign pl[k+1][i] = pl[k][i] & pl[k][i-D];
        end
      end else begin : g_cp
        assign gl[k+1][i] = gl[k][i];
        if (k + 1 < L) begin : g_p
          assign pl[k+1][i] = pl[k][i];
        end
      end
    end
  end
  assign c = {gl[L][N-2:0], 1'b1};
  assign diff = p ^ c;
  assign borrow = ~gl[L][N-1];
endmodule

// File: rtl/prefix_divider.sv
// prefix_divider: radix-2 restoring signed/unsigned divider, one quotient bit per clock
module prefix_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_dz
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] r, r_sh, diff;
  logic [WIDTH-1:0] q, dvs, a_abs, b_abs;
  logic sn_a, sn_b, a_neg, b_neg, borrow, special;
  assign a_neg = i_signed & i_dividend[WIDTH-1];
  assign b_neg = i_signed & i_divisor[WIDTH-1];
  assign a_abs = a_neg ? ~i_dividend + ONE : i_dividend;
  assign b_abs = b_neg ? ~i_divisor + ONE : i_divisor;
  assign special = (i_divisor == '0) | (i_signed & (i_dividend == MIN) & (i_divisor == '1));
  assign r_sh = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
  prefix_sub #(.N(WIDTH + 1)) u_sub (
    .a(r_sh),
    .b({1'b0, dvs}),
    .diff(diff),
    .borrow(borrow)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_start ? (special ? SPECIAL : CALC) : IDLE;
      SPECIAL: nxt = DONE;
      CALC:    nxt = (cnt == '0) ? FIXUP : CALC;
      FIXUP:   nxt = DONE;
      DONE:    nxt = i_ack ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
  end
  // operand capture, shift-subtract iterations and result formation
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      sn_a <= 1'b0;
      sn_b <= 1'b0;
      o_quot <= '0;
      o_rem <= '0;
      o_dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          q <= a_abs;
          dvs <= b_abs;
          r <= '0;
          sn_a <= a_neg;
          sn_b <= b_neg;
          cnt <= CW'(WIDTH - 1);
        end
        SPECIAL: begin
          o_dz <= dvs == '0;
          o_quot <= (dvs == '0) ? '1 : MIN;
          o_rem <= (dvs == '0) ? (sn_a ? ~q + ONE : q) : '0;
        end
        CALC: begin
          r <= borrow ? r_sh : diff;
          q <= {q[WIDTH-2:0], ~borrow};
          cnt <= cnt - CW'(1);
        end
        FIXUP: begin
          o_dz <= 1'b0;
          o_quot <= (sn_a ^ sn_b) ? ~q + ONE : q;
          o_rem <= sn_a ? ~r[WIDTH-1:0] + ONE : r[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prefix_divider.sv
// tb_prefix_divider: directed vectors, corner sequences and a reference-model sweep
module tb_prefix_divider;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_signed = 1'b0, i_ack = 1'b0;
  logic [W-1:0] i_dividend = '0, i_divisor = '0;
  logic o_ready, o_valid, o_dz;
  logic [W-1:0] o_quot, o_rem;
  int checks = 0, errors = 0;
  typedef struct {
    logic sgn;
    logic [W-1:0] a, b, q, r;
    logic dz;
    int lat;
  } vec_t;
  vec_t tv[13];

  prefix_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_signed(i_signed),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .o_ready(o_ready),
    .o_valid(o_valid), .i_ack(i_ack), .o_quot(o_quot), .o_rem(o_rem), .o_dz(o_dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    i_signed = sgn;
    i_dividend = a;
    i_divisor = b;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_dividend = ~a;
    i_divisor = $urandom;
    i_signed = ~sgn;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    i_ack = 1'b0;
  endtask

  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz, output int lat);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    dz = b == 0;
    lat = 34;
    if (b == 0) begin
      q = '1;
      r = a;
      lat = 2;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
      lat = 2;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    int lat, elat;
    logic [W-1:0] eq, er;
    logic edz, s;
    logic [W-1:0] a, b;
    tv[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34};
    tv[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
    tv[2]  = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34};
    tv[3]  = '{1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 2};
    tv[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 2};
    tv[5]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34};
    tv[6]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 34};
    tv[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34};
    tv[8]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 34};
    tv[9]  = '{1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 2};
    tv[10] = '{1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34};
    tv[11] = '{1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 34};
    tv[12] = '{1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 34};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", W'(o_ready), 1);
    chk("reset valid", W'(o_valid), 0);
    chk("reset quot", o_quot, 0);
    chk("reset rem", o_rem, 0);
    chk("reset dz", W'(o_dz), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 13; n++) begin
      run(tv[n].sgn, tv[n].a, tv[n].b, lat);
      chk($sformatf("vec%0d latency", n), W'(lat), W'(tv[n].lat));
      chk($sformatf("vec%0d quot", n), o_quot, tv[n].q);
      chk($sformatf("vec%0d rem", n), o_rem, tv[n].r);
      chk($sformatf("vec%0d dz", n), W'(o_dz), W'(tv[n].dz));
      ack();
      chk($sformatf("vec%0d valid after ack", n), W'(o_valid), 0);
      chk($sformatf("vec%0d ready after ack", n), W'(o_ready), 1);
    end

    i_signed = 1'b0;
    i_dividend = 32'd100;
    i_divisor = 32'd7;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort ready", W'(o_ready), 1);
    chk("abort valid", W'(o_valid), 0);
    chk("abort quot", o_quot, 0);
    chk("abort rem", o_rem, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort no result", W'(o_valid), 0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("post-abort latency", W'(lat), 34);
    chk("post-abort quot", o_quot, 32'hFFFF_FFFD);
    chk("post-abort rem", o_rem, 32'hFFFF_FFFF);
    ack();

    run(1'b0, 32'd1000, 32'd3, lat);
    chk("hold latency", W'(lat), 34);
    for (int j = 0; j < 20; j++) begin
      i_start = j[0];
      i_dividend = $urandom;
      i_divisor = $urandom;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d valid", j), W'(o_valid), 1);
      chk($sformatf("hold%0d ready", j), W'(o_ready), 0);
      chk($sformatf("hold%0d quot", j), o_quot, 32'd333);
      chk($sformatf("hold%0d rem", j), o_rem, 32'd1);
    end
    i_start = 1'b1;
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    i_ack = 1'b0;
    i_start = 1'b0;
    chk("ack+start valid", W'(o_valid), 0);
    chk("ack+start ready", W'(o_ready), 1);
    chk("ack keeps quot", o_quot, 32'd333);
    @(posedge clk);
    #1;
    chk("start with ack ignored", W'(o_ready), 1);

    for (int n = 0; n < 1000; n++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = '1;
        3: a = 32'h8000_0000;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (n % 8 == 3) b = s ? 32'hFFFF_FFFF : $urandom;
      if (n % 8 != 0 && n % 8 != 1 && n % 8 != 2 && n % 8 != 3) b = b;
      model(s, a, b, eq, er, edz, elat);
      run(s, a, b, lat);
      chk($sformatf("rnd%0d %0d %h/%h latency", n, s, a, b), W'(lat), W'(elat));
      chk($sformatf("rnd%0d %0d %h/%h quot", n, s, a, b), o_quot, eq);
      chk($sformatf("rnd%0d %0d %h/%h rem", n, s, a, b), o_rem, er);
      chk($sformatf("rnd%0d %0d %h/%h dz", n, s, a, b), W'(o_dz), W'(edz));
      ack();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
